bpm_link_collector: RTL and testbench

Downstream consumer of the per-link BPM packet reader. Gathers the 112-bit BPM records it emits (16-bit BPM index, X, Y, S) into a per-index sample buffer for each fast-acquisition cycle. Declares the cycle complete when every expected BPM has arrived, or incomplete on timeout. Also keeps reception statistics from the reader's status strobe, for the cell-controller register readout.

---
 rtl/bpm_link_collector.sv | 222 ++++++++++++++++++++++
 tb/tb_bpm_link_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_link_collector.sv
// Collects per-index BPM records into a sample buffer per acquisition cycle and keeps reception stats.
// Optional statistics counters are built only when BPM_COLLECTOR_STATS_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for cycleStart
// S_COLLECT | accepting records, timer running
// S_CLOSE   | one-cycle close: cycleDone high, results latched
module bpm_link_collector #(
    parameter int INDEX_WIDTH    = 5,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cycleStart,
    input  logic [INDEX_WIDTH:0]   expectedCount,
    input  logic                   inStrobe,
    input  logic [111:0]           inData,
    input  logic                   statusStrobe,
    input  logic [1:0]             statusCode,
    input  logic [INDEX_WIDTH-1:0] readAddress,
    output logic [95:0]            readData,
    output logic                   readValid,
    output logic                   cycleDone,
    output logic                   cycleComplete,
    output logic                   cycleOverrun,
    output logic [INDEX_WIDTH:0]   receivedCount,
    output logic                   busy,
    input  logic                   countersClear,
    output logic [15:0]            statCount0,
    output logic [15:0]            statCount1,
    output logic [15:0]            statCount2,
    output logic [15:0]            statCount3,
    output logic [15:0]            rejectCount
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CLOSE   = 2'd2;

    logic [1:0]             state;
    logic [TW-1:0]          timer;
    logic [DEPTH-1:0]       bitmap;
    logic [DEPTH-1:0]       valid_map;
    logic [INDEX_WIDTH:0]   unique_count;
    logic [INDEX_WIDTH:0]   exp_count;
    logic                   restart_pending;
    logic [INDEX_WIDTH:0]   restart_count;
    logic [95:0]            buffer [DEPTH];

    logic                   start_now;
    logic [INDEX_WIDTH:0]   start_exp;
    logic [INDEX_WIDTH:0]   cur_exp;
    logic [DEPTH-1:0]       base_map;
    logic [INDEX_WIDTH:0]   base_count;
    logic                   in_window;
    logic [15:0]            idx;
    logic [INDEX_WIDTH-1:0] idx_lo;
    logic                   in_range;
    logic                   accept;
    logic                   reject;
    logic [DEPTH-1:0]       idx_onehot;
    logic [DEPTH-1:0]       map_next;
    logic [INDEX_WIDTH:0]   count_next;
    logic                   close_now;
    logic                   close_complete;
    logic                   close_overrun;

    // A start seen in CLOSE (new pulse or one deferred from an overrun) behaves like IDLE + cycleStart.
    always_comb begin
        start_now = 1'b0;
        start_exp = expectedCount;
        if (state == S_IDLE && cycleStart) begin
            start_now = 1'b1;
        end
        if (state == S_CLOSE && (cycleStart || restart_pending)) begin
            start_now = 1'b1;
            if (!cycleStart) begin
                start_exp = restart_count;
            end
        end
    end

    assign cur_exp    = start_now ? start_exp : exp_count;
    assign base_map   = start_now ? '0 : bitmap;
    assign base_count = start_now ? '0 : unique_count;
    assign in_window  = start_now || (state == S_COLLECT);

    assign idx        = inData[111:96];
    assign idx_lo     = idx[INDEX_WIDTH-1:0];
    assign in_range   = ((idx >> INDEX_WIDTH) == 16'd0) && ({1'b0, idx_lo} < cur_exp);
    assign accept     = inStrobe && in_window && in_range && !base_map[idx_lo];
    assign reject     = inStrobe && !accept;
    assign idx_onehot = DEPTH'(1) << idx_lo;
    assign map_next   = base_map | (accept ? idx_onehot : '0);
    assign count_next = base_count + {{INDEX_WIDTH{1'b0}}, accept};

    always_comb begin
        close_now      = 1'b0;
        close_complete = 1'b0;
        close_overrun  = 1'b0;
        if (start_now) begin
            if (count_next == start_exp) begin
                close_now      = 1'b1;
                close_complete = 1'b1;
            end
        end else if (state == S_COLLECT) begin
            if (cycleStart) begin
                close_now     = 1'b1;
                close_overrun = 1'b1;
            end else if (count_next == exp_count) begin
                close_now      = 1'b1;
                close_complete = 1'b1;
            end else if (timer == '0) begin
                close_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            timer           <= '0;
            bitmap          <= '0;
            valid_map       <= '0;
            unique_count    <= '0;
            exp_count       <= '0;
            restart_pending <= 1'b0;
            restart_count   <= '0;
            cycleComplete   <= 1'b0;
            cycleOverrun    <= 1'b0;
            receivedCount   <= '0;
        end else begin
            if (start_now) begin
                exp_count <= start_exp;
                timer     <= TIMER_LOAD;
            end else if (state == S_COLLECT && timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (in_window) begin
                bitmap       <= map_next;
                unique_count <= count_next;
            end
            restart_pending <= 1'b0;
            if (state == S_COLLECT && cycleStart) begin
                restart_pending <= 1'b1;
                restart_count   <= expectedCount;
            end
            if (close_now) begin
                state         <= S_CLOSE;
                cycleComplete <= close_complete;
                cycleOverrun  <= close_overrun;
                receivedCount <= count_next;
                valid_map     <= map_next;
            end else if (start_now) begin
                state <= S_COLLECT;
            end else if (state == S_CLOSE) begin
                state <= S_IDLE;
            end
        end
    end

    // Sample memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (resetn && accept) begin
            buffer[idx_lo] <= inData[95:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            readData  <= buffer[readAddress];
            readValid <= valid_map[readAddress];
        end
    end

    assign cycleDone = (state == S_CLOSE);
    assign busy      = (state == S_COLLECT);

`ifdef BPM_COLLECTOR_STATS_EN
    logic [15:0] stat_count [4];
    logic [15:0] reject_count;

    always_ff @(posedge clk) begin
        if (!resetn || countersClear) begin
            for (int i = 0; i < 4; i++) begin
                stat_count[i] <= '0;
            end
            reject_count <= '0;
        end else begin
            if (statusStrobe && stat_count[statusCode] != 16'hFFFF) begin
                stat_count[statusCode] <= stat_count[statusCode] + 16'd1;
            end
            if (reject && reject_count != 16'hFFFF) begin
                reject_count <= reject_count + 16'd1;
            end
        end
    end

    assign statCount0  = stat_count[0];
    assign statCount1  = stat_count[1];
    assign statCount2  = stat_count[2];
    assign statCount3  = stat_count[3];
    assign rejectCount = reject_count;
`else
    logic unused_stats;
    assign unused_stats = ^{countersClear, statusStrobe, statusCode, reject};
    assign statCount0   = '0;
    assign statCount1   = '0;
    assign statCount2   = '0;
    assign statCount3   = '0;
    assign rejectCount  = '0;
`endif

endmodule

// File: tb/tb_bpm_link_collector.sv
// Directed bench for bpm_link_collector: complete, timeout, rejects, overrun, stats, reset.
module tb_bpm_link_collector;

    localparam int IW = 5;
    localparam int TO = 20;
`ifdef BPM_COLLECTOR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          cycleStart;
    logic [IW:0]   expectedCount;
    logic          inStrobe;
    logic [111:0]  inData;
    logic          statusStrobe;
    logic [1:0]    statusCode;
    logic [IW-1:0] readAddress;
    logic [95:0]   readData;
    logic          readValid;
    logic          cycleDone;
    logic          cycleComplete;
    logic          cycleOverrun;
    logic [IW:0]   receivedCount;
    logic          busy;
    logic          countersClear;
    logic [15:0]   statCount0, statCount1, statCount2, statCount3, rejectCount;

    int total = 0;
    int bad   = 0;
    int n;
    int dones;

    bpm_link_collector #(.INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .cycleStart(cycleStart), .expectedCount(expectedCount),
        .inStrobe(inStrobe), .inData(inData), .statusStrobe(statusStrobe), .statusCode(statusCode),
        .readAddress(readAddress), .readData(readData), .readValid(readValid),
        .cycleDone(cycleDone), .cycleComplete(cycleComplete), .cycleOverrun(cycleOverrun),
        .receivedCount(receivedCount), .busy(busy), .countersClear(countersClear),
        .statCount0(statCount0), .statCount1(statCount1), .statCount2(statCount2),
        .statCount3(statCount3), .rejectCount(rejectCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record with X = x, Y = x + 0x100, S = x + 0x200.
    task automatic send(input logic [15:0] idx, input logic [31:0] x);
        inStrobe = 1'b1;
        inData   = {idx, x, x + 32'h100, x + 32'h200};
        tick();
        inStrobe = 1'b0;
    endtask

    task automatic start(input logic [IW:0] exp);
        cycleStart    = 1'b1;
        expectedCount = exp;
        tick();
        cycleStart = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int waited);
        waited = 0;
        while (!cycleDone && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; cycleStart = 1'b0; expectedCount = '0; inStrobe = 1'b0; inData = '0;
        statusStrobe = 1'b0; statusCode = 2'd0; readAddress = '0; countersClear = 1'b0;
        repeat (3) tick();
        check("rst_done", cycleDone, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_complete", cycleComplete, 1'b0);
        check("rst_count", receivedCount, 0);
        check("rst_valid", readValid, 1'b0);
        check("rst_data", readData, 0);
        check("rst_reject", rejectCount, 0);
        resetn = 1'b1;
        tick();

        // complete cycle
        start(6'd4);
        check("c1_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) send(16'(i), 32'h100 + 32'(i));
        check("c1_done", cycleDone, 1'b1);
        check("c1_complete", cycleComplete, 1'b1);
        check("c1_overrun", cycleOverrun, 1'b0);
        check("c1_count", receivedCount, 4);
        readAddress = 5'd2;
        tick();
        check("c1_done_clear", cycleDone, 1'b0);
        check("c1_rdata", readData, {32'h102, 32'h202, 32'h302});
        check("c1_rvalid", readValid, 1'b1);

        // timeout: done seen TO edges after the start edge (TO+1 clocks after cycleStart)
        start(6'd4);
        send(16'd0, 32'h500);
        send(16'd3, 32'h503);
        wait_done(100, n);
        check("to_latency", 2 + n, TO);
        check("to_done", cycleDone, 1'b1);
        check("to_complete", cycleComplete, 1'b0);
        check("to_count", receivedCount, 2);
        readAddress = 5'd1;
        tick();
        check("to_rvalid1", readValid, 1'b0);
        readAddress = 5'd3;
        tick();
        check("to_rvalid3", readValid, 1'b1);

        // rejects: IDLE record, duplicate, out of range, high index bits set
        send(16'd5, 32'h777);
        start(6'd4);
        send(16'd1, 32'hAAA);
        send(16'd1, 32'hBBB);
        send(16'd7, 32'hCCC);
        send(16'h0021, 32'hDDD);
        send(16'd0, 32'h010);
        wait_done(100, n);
        check("rj_done", cycleDone, 1'b1);
        check("rj_count", receivedCount, 2);
        check("rj_rejects", rejectCount, STATS_ON ? 16'd4 : 16'd0);
        readAddress = 5'd1;
        tick();
        check("rj_buf1", readData, {32'hAAA, 32'hBAA, 32'hCAA});
        check("rj_valid1", readValid, 1'b1);

        // expectedCount = 0 closes immediately as complete
        start(6'd0);
        check("z_done", cycleDone, 1'b1);
        check("z_complete", cycleComplete, 1'b1);
        check("z_count", receivedCount, 0);
        tick();
        check("z_idle", busy, 1'b0);

        // overrun: second cycleStart mid-COLLECT
        start(6'd4);
        send(16'd0, 32'h900);
        start(6'd2);
        check("ov_done", cycleDone, 1'b1);
        check("ov_flag", cycleOverrun, 1'b1);
        check("ov_complete", cycleComplete, 1'b0);
        check("ov_count", receivedCount, 1);
        tick();
        check("ov_fresh_busy", busy, 1'b1);
        check("ov_done_clear", cycleDone, 1'b0);
        send(16'd0, 32'h910);
        send(16'd1, 32'h911);
        check("ov2_done", cycleDone, 1'b1);
        check("ov2_complete", cycleComplete, 1'b1);
        check("ov2_overrun", cycleOverrun, 1'b0);
        check("ov2_count", receivedCount, 2);
        tick();

        // record on the same clock as cycleStart belongs to the new cycle
        cycleStart = 1'b1; expectedCount = 6'd2;
        inStrobe = 1'b1; inData = {16'd1, 32'hE01, 32'hF01, 32'h1001};
        tick();
        cycleStart = 1'b0; inStrobe = 1'b0;
        check("sc_busy", busy, 1'b1);
        send(16'd0, 32'hE00);
        check("sc_done", cycleDone, 1'b1);
        check("sc_complete", cycleComplete, 1'b1);
        check("sc_count", receivedCount, 2);
        tick();

        // statistics
        statusStrobe = 1'b1;
        statusCode = 2'd0; repeat (3) tick();
        statusCode = 2'd3; tick();
        statusStrobe = 1'b0;
        tick();
        check("st_code0", statCount0, STATS_ON ? 16'd3 : 16'd0);
        check("st_code3", statCount3, STATS_ON ? 16'd1 : 16'd0);
        check("st_code2", statCount2, 16'd0);
        statusStrobe = 1'b1; statusCode = 2'd1;
        repeat (STATS_ON ? 70000 : 10) tick();
        statusStrobe = 1'b0;
        tick();
        check("st_sat1", statCount1, STATS_ON ? 16'hFFFF : 16'd0);
        check("st_rej_hold", rejectCount, STATS_ON ? 16'd4 : 16'd0);
        countersClear = 1'b1; statusStrobe = 1'b1; statusCode = 2'd2;
        tick();
        countersClear = 1'b0; statusStrobe = 1'b0;
        check("st_clr0", statCount0, 16'd0);
        check("st_clr1", statCount1, 16'd0);
        check("st_clr2", statCount2, 16'd0);
        check("st_clr_rej", rejectCount, 16'd0);

        // reset mid-COLLECT
        readAddress = 5'd0;
        start(6'd4);
        send(16'd0, 32'h123);
        resetn = 1'b0;
        tick();
        check("mr_busy", busy, 1'b0);
        check("mr_done", cycleDone, 1'b0);
        check("mr_complete", cycleComplete, 1'b0);
        check("mr_overrun", cycleOverrun, 1'b0);
        check("mr_count", receivedCount, 0);
        check("mr_rvalid", readValid, 1'b0);
        check("mr_rdata", readData, 0);
        resetn = 1'b1;
        dones = 0;
        repeat (TO + 10) begin
            tick();
            if (cycleDone) dones++;
        end
        check("mr_no_done", dones, 0);
        check("mr_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
